// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    IF_BOOT  = 2'd0,
    IF_RUN   = 2'd1,
    IF_REDIR = 2'd2
  } if_state_e;

  localparam logic [31:0] IF_BOOT_ADDR = 32'h0000_0004;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// DEPTH x 64-bit prefetch FIFO holding {pc, instr}; head is read combinationally.
// Flush clears pointers and count; storage itself is only cleared by reset.
module if_prefetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  logic [63:0] data_i,
  output logic [63:0] head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      // Simultaneous push and pop leaves the occupancy unchanged, even when full.
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= if_entry_t'(data_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues one SRAM word-read per cycle into a prefetch FIFO.
// Optional request/redirect counters are enabled with `define IF_PERF_CNT_EN.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = IF_BOOT_ADDR,
  parameter int          DEPTH     = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        imem_req_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_flush_o
`endif
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req;
  logic        pop;
  logic        full;
  logic        empty;
  logic [63:0] head;
  if_entry_t   push_entry;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign pop = instr_valid_o && instr_ready_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req     = 1'b0;
    case (state_q)
      IF_BOOT:  state_d = IF_RUN;
      IF_RUN:   req     = !full || pop;
      IF_REDIR: state_d = IF_RUN;
      default:  state_d = IF_BOOT;
    endcase
    if (req) pc_d = pc_q + 32'd4;
    // A redirect overrides everything, including a fetch that would otherwise issue.
    if (redirect_i) begin
      req     = 1'b0;
      pc_d    = {redirect_pc_i[31:2], 2'b00};
      state_d = IF_REDIR;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IF_BOOT;
      pc_q    <= BOOT_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign push_entry = '{pc: pc_q, instr: imem_rdata_i};

  if_prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (req),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .data_i  (push_entry),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign imem_req_o    = req;
  assign imem_we_o     = 1'b0;
  assign imem_wdata_o  = 32'd0;
  assign imem_addr_o   = {2'b00, pc_q[31:2]};
  assign instr_valid_o = !empty;
  assign instr_pc_o    = head[63:32];
  assign instr_o       = head[31:0];

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_flush_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (req)        perf_fetch_q <= perf_fetch_q + 32'd1;
      if (redirect_i) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage for the core; sits directly upstream of the instruction SRAM and directly upstream of decode. It owns the program counter and issues one word-read per cycle to the instruction memory. The returned word is captured together with its PC in a small prefetch FIFO, and the FIFO head is presented to decode over a valid/ready handshake. Branch redirects from execute flush the FIFO and restart fetch at the target.

## Interface
- BOOT_ADDR, 32'h0000_0004: byte address of the first fetch after reset.
- DEPTH, 4: prefetch FIFO entries; power of two, 2..16.
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  reset; asynchronous, active-low.
- imem_req_o  out  1  read request to instruction SRAM.
- imem_we_o  out  1  constant 0.
- imem_addr_o  out  32  word address, {2'b00, pc_q[31:2]}.
- imem_wdata_o  out  32  constant 0.
- imem_rdata_i  in  32  read data; combinational on imem_addr_o, valid in the same cycle.
- redirect_i  in  1  branch taken; flush and restart.
- redirect_pc_i  in  32  target byte address; bits [1:0] are ignored and forced to 0.
- instr_valid_o  out  1  FIFO head valid.
- instr_o  out  32  instruction at FIFO head.
- instr_pc_o  out  32  byte PC of instr_o.
- instr_ready_i  in  1  decode accepts the head this cycle.

## Operation
- FSM states are BOOT, RUN and REDIR.
  - BOOT: entered on reset. No request is issued. Moves to RUN after one cycle.
  - RUN: imem_req_o = !full || pop, where pop = instr_valid_o && instr_ready_i. On each request, {pc_q, imem_rdata_i} is pushed and pc_q advances by 4.
  - REDIR: one cycle, no request. Returns to RUN.
- redirect_i is sampled in any state and has priority over everything else:
  - FIFO pointers and count clear at the edge.
  - pc_q is loaded with {redirect_pc_i[31:2], 2'b00}.
  - State moves to REDIR.
  - imem_req_o is forced low in the redirect cycle itself.
  - A pop in the same cycle is still accepted by decode; the flush discards all remaining entries.
- Push and pop in the same cycle on a full FIFO is allowed; count is unchanged.
- Pop on an empty FIFO cannot occur, because instr_valid_o is low when empty.
- pc_q wraps modulo 2^32. There is no alignment fault.
- FIFO count is a $clog2(DEPTH)+1 bit counter. Read and write pointers wrap naturally.
- The head is driven combinationally from FIFO storage at the read pointer.

## Timing
- Reset values:
  - imem_req_o = 0, instr_valid_o = 0.
  - instr_o = 0, instr_pc_o = 0.
  - pc_q = BOOT_ADDR, state = BOOT, count = 0.
- Reset asserted mid-operation clears everything asynchronously. No stale entry survives.
- Boot sequence (edges counted after reset release):
  - First cycle is BOOT, with no request.
  - Second cycle: first request, imem_addr_o = BOOT_ADDR>>2.
  - instr_valid_o rises in the following cycle.
- Fetch-to-valid latency is 1 cycle. Sustained throughput is 1 instruction per cycle while decode is ready.
- Redirect penalty:
  - Cycle of redirect_i: no request.
  - Next cycle (REDIR): no request.
  - Following cycle: request at the target.
  - The target instruction is valid 3 cycles after the redirect cycle.
- Backpressure: with instr_ready_i low, the FIFO fills in DEPTH cycles and then imem_req_o drops. The head is held stable until accepted.

## Configuration
- IF_PERF_CNT_EN defined:
  - Adds outputs perf_fetch_o [31:0] (count of issued requests) and perf_flush_o [31:0] (count of redirect cycles).
  - Both reset to 0 and wrap at 2^32.
- IF_PERF_CNT_EN undefined: both ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package if_pkg holds:
  - The state encoding typedef (IF_BOOT, IF_RUN, IF_REDIR).
  - The default BOOT_ADDR constant.
  - The fetch-entry struct {pc[31:0], instr[31:0]}.
- One sub-module, if_prefetch_fifo: a parameterised DEPTH x 64-bit synchronous FIFO with push, pop, flush, full, empty and head data.

## Test plan
- Reset release, instr_ready_i=1, memory word1=32'h0000_0033:
  - imem_addr_o sequence is 1, 2, 3, ...
  - First output is instr_o=32'h0000_0033, instr_pc_o=32'h4, one cycle after the first request.
- instr_ready_i=0 from reset, DEPTH=4:
  - Exactly 4 requests are issued (addresses 1..4), then imem_req_o=0.
  - Head holds pc 32'h4.
  - Raising ready drains pcs 4, 8, 12, 16 in order with no gaps, and fetch resumes at address 5.
- Redirect to 32'h0000_0040 while the FIFO holds 3 entries:
  - Next cycle instr_valid_o=0.
  - imem_req_o is low for 2 cycles, then imem_addr_o=16.
  - First valid output has instr_pc_o=32'h40.
- redirect_pc_i=32'h0000_0043: fetch restarts at byte 32'h40, word 16.
- Reset asserted while full, then released: instr_valid_o=0 immediately, and the fetch sequence restarts at BOOT_ADDR.
- With IF_PERF_CNT_EN: 10 sequential fetches plus 1 redirect give perf_fetch_o=10 and perf_flush_o=1.
